// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_unit_if                                          |
// | Description : Instruction-memory request/grant/response bundle used  |
// |               between the fetch unit (master) and instruction memory |
// |               (slave).                                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_unit                                             |
// | Description : Instruction-fetch front end. Holds the PC, runs one    |
// |               outstanding request/grant/response to instruction      |
// |               memory, presents the fetched instruction to IF/ID      |
// |               until accepted, and handles branch redirects including |
// |               discarding of in-flight responses.                     |
// |               Optional macro FETCH_PERF_EN adds fetched/dropped      |
// |               response counters.                                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  input  wire logic        stall_i,
  input  wire logic        redirect_i,
  input  wire logic [31:0] redirect_pc_i,
  fetch_unit_if.master     imem,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_o,
  output logic             valid_o,
  output logic             bubble_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched_o,
  output logic [31:0]      perf_dropped_o
`endif
);

  localparam logic [31:0] c_PC_STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_pc_out;
  logic [31:0] w_pc_out_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        w_capture;
  logic        w_discard;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode; a redirect always overrides the PC
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_drop_nxt   = r_drop;
    w_instr_nxt  = r_instr;
    w_pc_out_nxt = r_pc_out;
    w_valid_nxt  = r_valid;
    w_capture    = 1'b0;
    w_discard    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // A request granted in the same cycle as a redirect is already in
        // memory's hands; its response must be thrown away later.
        if (imem.imem_gnt_i) begin
          w_state_nxt = S_WAIT;
          w_drop_nxt  = redirect_i;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid_i) begin
          if (r_drop || redirect_i) begin
            w_discard   = 1'b1;
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_capture    = 1'b1;
            w_instr_nxt  = imem.imem_rdata_i;
            w_pc_out_nxt = r_pc;
            w_valid_nxt  = 1'b1;
            w_pc_nxt     = r_pc + c_PC_STEP;
            w_state_nxt  = S_HOLD;
          end
        end else if (redirect_i) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // Consumed by IF/ID, or killed by a redirect (which beats stall)
        if (redirect_i || !stall_i) begin
          w_instr_nxt  = 32'h0;
          w_pc_out_nxt = 32'h0;
          w_valid_nxt  = 1'b0;
          w_state_nxt  = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (redirect_i) begin
      w_pc_nxt = redirect_pc_i;
    end
  end

  // PC, drop flag and IF/ID-facing output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc     <= RESET_PC;
      r_drop   <= 1'b0;
      r_instr  <= 32'h0;
      r_pc_out <= 32'h0;
      r_valid  <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_drop   <= w_drop_nxt;
      r_instr  <= w_instr_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;

  // Free-running wrap-around counters of captured and discarded responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_fetched <= 32'h0;
      r_perf_dropped <= 32'h0;
    end else begin
      r_perf_fetched <= r_perf_fetched + {31'h0, w_capture};
      r_perf_dropped <= r_perf_dropped + {31'h0, w_discard};
    end
  end

  assign perf_fetched_o = r_perf_fetched;
  assign perf_dropped_o = r_perf_dropped;
`else
  // Keeps the discard decode visible even without counters attached
  logic w_discard_unused;
  assign w_discard_unused = w_discard & w_capture;
`endif

  assign imem.imem_req_o  = (r_state == S_REQ);
  assign imem.imem_addr_o = r_pc;
  assign instr_o          = r_instr;
  assign pc_o             = r_pc_out;
  assign valid_o          = r_valid;
  assign bubble_o         = ~r_valid & ~stall_i;

endmodule
`default_nettype wire
